xbus_io_ctrl: RTL

Parametrised Wishbone (XBUS) slave peripheral for the NEORV32 home-automation SoC. It drives N_OUT actuator outputs (lock, alarm, air-conditioner, lamp, ...) and samples N_IN sensor inputs (fire, presence, ...).
- Outputs support set, clear, toggle and timed one-shot pulse, e.g. auto-relocking the door lock.
- Inputs are synchronised and debounced, and latch sticky rising-edge events that raise a maskable interrupt.
- Sits directly on the CPU's XBUS port; output polarity inversion for the LEDs stays in the top level.

---
 rtl/xbus_io_pkg.sv | 21 ++
 rtl/xbus_io_ctrl_debounce.sv | 53 +++++
 rtl/xbus_io_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/xbus_io_pkg.sv
// Register map and sizing helpers shared by the XBUS I/O controller and its input channels.
// All offsets are word indices taken from wb_adr_i[5:2].
package xbus_io_pkg;

  localparam int ADR_W = 4;

  localparam logic [ADR_W-1:0] OFS_OUT        = 4'h0;
  localparam logic [ADR_W-1:0] OFS_OUT_SET    = 4'h1;
  localparam logic [ADR_W-1:0] OFS_OUT_CLR    = 4'h2;
  localparam logic [ADR_W-1:0] OFS_OUT_TGL    = 4'h3;
  localparam logic [ADR_W-1:0] OFS_PULSE_LEN  = 4'h4;
  localparam logic [ADR_W-1:0] OFS_PULSE_TRIG = 4'h5;
  localparam logic [ADR_W-1:0] OFS_IN         = 4'h6;
  localparam logic [ADR_W-1:0] OFS_EVT        = 4'h7;
  localparam logic [ADR_W-1:0] OFS_EVT_EN     = 4'h8;

  function automatic int deb_cnt_w(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/xbus_io_ctrl_debounce.sv
// One sensor input: 2-FF synchroniser, stability counter and rising-edge strobe.
// Debounced level follows a clean raw edge after 2+DEB_CYCLES cycles; rise_o pulses on that edge.
module io_debounce
  import xbus_io_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o,
  output logic rise_o
);

  localparam int CW = deb_cnt_w(DEB_CYCLES);

  logic          sync0_q, sync0_d, sync1_q, sync1_d, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with the debounced one restarts the count.
  always_comb begin
    sync0_d = raw_i;
    sync1_d = sync0_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    rise_o  = 1'b0;
    if (sync1_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d  = sync1_q;
        rise_o = sync1_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/xbus_io_ctrl.sv
// Wishbone slave driving actuator outputs (set/clr/toggle/timed pulse) and debounced sensor events.
// ack/err one cycle after a request, then one idle cycle; never stalls beyond that.
module xbus_io_ctrl
  import xbus_io_pkg::*;
#(
  parameter int N_OUT      = 4,
  parameter int N_IN       = 2,
  parameter int TIMER_W    = 24,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic [N_OUT-1:0] out_o,
  input  logic [N_IN-1:0]  in_i,
  output logic             irq_o
);

  logic [N_OUT-1:0]   out_q, out_d;
  logic [TIMER_W-1:0] cnt_q [N_OUT];
  logic [TIMER_W-1:0] cnt_d [N_OUT];
  logic [TIMER_W-1:0] plen_q, plen_d;
  logic [N_IN-1:0]    evt_q, evt_d, en_q, en_d, deb, rise, w1c;
  logic               ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]        dat_q, dat_d, bm, wdat_m, rd;
  logic [ADR_W-1:0]   adr;
  logic               req, wr;
  logic               unused_bits;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (in_i[i]),
      .deb_o  (deb[i]),
      .rise_o (rise[i])
    );
  end

  always_comb begin
    bm     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wdat_m = wb_dat_i & bm;
    adr    = wb_adr_i[ADR_W+1:2];
    req    = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    ack_d  = req & (adr <= OFS_EVT_EN);
    err_d  = req & (adr > OFS_EVT_EN);
    wr     = ack_d & wb_we_i;
    rd     = '0;
    case (adr)
      OFS_OUT:       rd[N_OUT-1:0]   = out_q;
      OFS_PULSE_LEN: rd[TIMER_W-1:0] = plen_q;
      OFS_IN:        rd[N_IN-1:0]    = deb;
      OFS_EVT:       rd[N_IN-1:0]    = evt_q;
      OFS_EVT_EN:    rd[N_IN-1:0]    = en_q;
      default:       rd              = '0;
    endcase
    dat_d = (ack_d & ~wb_we_i) ? rd : '0;
    irq_d = |(evt_q & en_q);
  end

  // Expiry is applied first so that a software write on the same edge overrides it.
  always_comb begin
    out_d  = out_q;
    cnt_d  = cnt_q;
    plen_d = plen_q;
    en_d   = en_q;
    w1c    = '0;
    for (int c = 0; c < N_OUT; c++) begin
      if (cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - TIMER_W'(1);
        if (cnt_q[c] == TIMER_W'(1)) out_d[c] = 1'b0;
      end
    end
    if (wr) begin
      case (adr)
        OFS_OUT:
          for (int c = 0; c < N_OUT; c++)
            if (bm[c]) begin out_d[c] = wb_dat_i[c]; cnt_d[c] = '0; end
        OFS_OUT_SET:
          for (int c = 0; c < N_OUT; c++)
            if (wdat_m[c]) begin out_d[c] = 1'b1; cnt_d[c] = '0; end
        OFS_OUT_CLR:
          for (int c = 0; c < N_OUT; c++)
            if (wdat_m[c]) begin out_d[c] = 1'b0; cnt_d[c] = '0; end
        OFS_OUT_TGL:
          for (int c = 0; c < N_OUT; c++)
            if (wdat_m[c]) begin out_d[c] = ~out_q[c]; cnt_d[c] = '0; end
        OFS_PULSE_LEN:
          plen_d = (plen_q & ~bm[TIMER_W-1:0]) | wdat_m[TIMER_W-1:0];
        OFS_PULSE_TRIG:
          for (int c = 0; c < N_OUT; c++)
            if (wdat_m[c] && plen_q != '0) begin out_d[c] = 1'b1; cnt_d[c] = plen_q; end
        OFS_EVT:    w1c  = wdat_m[N_IN-1:0];
        OFS_EVT_EN: en_d = (en_q & ~bm[N_IN-1:0]) | wdat_m[N_IN-1:0];
        default: ;
      endcase
    end
    evt_d = (evt_q & ~w1c) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      cnt_q  <= '{default: '0};
      plen_q <= '0;
      evt_q  <= '0;
      en_q   <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      plen_q <= plen_d;
      evt_q  <= evt_d;
      en_q   <= en_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end
  end

  assign unused_bits = ^{wb_adr_i[31:ADR_W+2], wb_adr_i[1:0], wdat_m, bm};

  assign out_o    = out_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule
